hazard_ctrl_unit: RTL and testbench

- Parametrised hazard controller for the 5-stage pipelined CPU; next generation of the standalone forwarding unit.
- Merges EX-stage operand forwarding (N_SRC sources) with load-use stall insertion of configurable length.
- Adds taken-branch/jump flush of younger stages and a data-memory-busy freeze.
- Drives every pipeline-register enable and flush, plus saturating stall/flush/wait event counters.

---
 rtl/hazard_ctrl_unit.sv | 195 +++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//
// Hazard controller for the 5-stage pipeline. It combines:
//   - EX-stage operand forwarding for N_SRC source operands (MEM wins over WB),
//   - load-use stall insertion lasting LU_STALL cycles,
//   - flushing of the younger stages when a taken branch or jump resolves in MEM,
//   - a full pipeline freeze while the data memory is busy,
//   - saturating counters for stall, flush and memory-wait cycles.
//
// Ports:
//   clk, arst             clock, asynchronous active-high reset
//   enable                global run enable; when low the pipeline is frozen
//   src_ID, src_used_ID   ID-stage source addresses and "operand is read" flags
//   src_EX                EX-stage source addresses (forwarding compare)
//   waddr_EX, mem_read_EX EX destination and "EX is a load"
//   waddr_MEM, reg_write_MEM, waddr_WB, reg_write_WB
//                         destinations and write flags of MEM and WB
//   redirect_MEM          taken branch/jump resolved in MEM
//   mem_busy              data memory not ready
//   fwd_sel               per source, 2 bits: 00 regfile, 01 MEM alu_out, 10 WB wdata
//   pc_en, *_en           PC and pipeline-register enables
//   *_flush               load a bubble into the register on the next edge
//   stall_cnt, flush_cnt, wait_cnt  saturating event counters
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int N_SRC      = 2,
    parameter int LU_STALL   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          enable,
    input  logic [N_SRC*REG_ADDR_W-1:0]   src_ID,
    input  logic [N_SRC-1:0]              src_used_ID,
    input  logic [N_SRC*REG_ADDR_W-1:0]   src_EX,
    input  logic [REG_ADDR_W-1:0]         waddr_EX,
    input  logic                          mem_read_EX,
    input  logic [REG_ADDR_W-1:0]         waddr_MEM,
    input  logic                          reg_write_MEM,
    input  logic [REG_ADDR_W-1:0]         waddr_WB,
    input  logic                          reg_write_WB,
    input  logic                          redirect_MEM,
    input  logic                          mem_busy,
    output logic [2*N_SRC-1:0]            fwd_sel,
    output logic                          pc_en,
    output logic                          if_id_en,
    output logic                          id_ex_en,
    output logic                          ex_mem_en,
    output logic                          mem_wb_en,
    output logic                          if_id_flush,
    output logic                          id_ex_flush,
    output logic                          ex_mem_flush,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt,
    output logic [CNT_W-1:0]              wait_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    // Remaining stall cycles loaded when a multi-cycle load-use stall starts;
    // the first stall cycle is spent in RUN, so only LU_STALL-1 remain.
    localparam logic [3:0] LU_REM = 4'(LU_STALL - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] rem;
    logic [3:0] rem_next;
    logic       lu;
    logic       stall_now;
    logic       stall_ev;
    logic       flush_ev;
    logic       wait_ev;

    // Forwarding select; held at zero during reset so nothing downstream
    // picks a bypass path from uninitialised pipeline registers.
    always_comb begin
        fwd_sel = '0;
        if (!arst) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (reg_write_MEM && (waddr_MEM != '0) &&
                    (waddr_MEM == src_EX[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    fwd_sel[2*i +: 2] = 2'b01;
                end else if (reg_write_WB && (waddr_WB != '0) &&
                             (waddr_WB == src_EX[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end
            end
        end
    end

    // Load-use: the load in EX produces its value too late for an ID
    // instruction that actually reads the same register. $0 never hazards.
    always_comb begin
        lu = 1'b0;
        if (mem_read_EX && (waddr_EX != '0)) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_used_ID[i] &&
                    (src_ID[i*REG_ADDR_W +: REG_ADDR_W] == waddr_EX)) begin
                    lu = 1'b1;
                end
            end
        end
    end

    assign stall_now = (state == LSTALL) || lu;

    // State register and saturating counters.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= RUN;
            rem       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            if (stall_ev && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_ev && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (wait_ev && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and event decode, in priority order:
    // enable low > mem_busy > redirect > load-use / LSTALL > normal.
    // A redirect squashes the stalled instruction, so a pending stall is dropped.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        wait_ev    = 1'b0;
        if (!enable) begin
            state_next = state;
        end else if (mem_busy) begin
            wait_ev = 1'b1;
        end else if (redirect_MEM) begin
            flush_ev   = 1'b1;
            state_next = RUN;
            rem_next   = '0;
        end else if (state == LSTALL) begin
            stall_ev = 1'b1;
            rem_next = rem - 4'd1;
            if (rem_next == 4'd0) begin
                state_next = RUN;
            end
        end else if (lu) begin
            stall_ev = 1'b1;
            if (LU_STALL > 1) begin
                state_next = LSTALL;
                rem_next   = LU_REM;
            end
        end
    end

    // Enables and flushes follow the same priority. A stall holds PC and
    // IF/ID and bubbles ID/EX so the load can advance to MEM.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!arst && enable && !mem_busy) begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (redirect_MEM) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (stall_now) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
//
// Directed bench for hazard_ctrl_unit. Three instances share one set of
// inputs: a (defaults, LU_STALL=1), b (LU_STALL=3), c (LU_STALL=5, CNT_W=2).
// Each check targets the instance whose parameters make it meaningful.
module tb_hazard_ctrl_unit;

    logic        clk;
    logic        arst;
    logic        enable;
    logic [9:0]  src_ID;
    logic [1:0]  src_used_ID;
    logic [9:0]  src_EX;
    logic [4:0]  waddr_EX;
    logic        mem_read_EX;
    logic [4:0]  waddr_MEM;
    logic        reg_write_MEM;
    logic [4:0]  waddr_WB;
    logic        reg_write_WB;
    logic        redirect_MEM;
    logic        mem_busy;

    logic [3:0]  a_fwd, b_fwd, c_fwd;
    logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en;
    logic        a_if_id_flush, a_id_ex_flush, a_ex_mem_flush;
    logic [15:0] a_stall_cnt, a_flush_cnt, a_wait_cnt;
    logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en;
    logic        b_if_id_flush, b_id_ex_flush, b_ex_mem_flush;
    logic [15:0] b_stall_cnt, b_flush_cnt, b_wait_cnt;
    logic        c_pc_en, c_if_id_en, c_id_ex_en, c_ex_mem_en, c_mem_wb_en;
    logic        c_if_id_flush, c_id_ex_flush, c_ex_mem_flush;
    logic [1:0]  c_stall_cnt, c_flush_cnt, c_wait_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .N_SRC(2), .LU_STALL(1), .CNT_W(16)) u_a (
        .clk(clk), .arst(arst), .enable(enable),
        .src_ID(src_ID), .src_used_ID(src_used_ID), .src_EX(src_EX),
        .waddr_EX(waddr_EX), .mem_read_EX(mem_read_EX),
        .waddr_MEM(waddr_MEM), .reg_write_MEM(reg_write_MEM),
        .waddr_WB(waddr_WB), .reg_write_WB(reg_write_WB),
        .redirect_MEM(redirect_MEM), .mem_busy(mem_busy),
        .fwd_sel(a_fwd), .pc_en(a_pc_en), .if_id_en(a_if_id_en),
        .id_ex_en(a_id_ex_en), .ex_mem_en(a_ex_mem_en), .mem_wb_en(a_mem_wb_en),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
        .ex_mem_flush(a_ex_mem_flush),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .wait_cnt(a_wait_cnt)
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .N_SRC(2), .LU_STALL(3), .CNT_W(16)) u_b (
        .clk(clk), .arst(arst), .enable(enable),
        .src_ID(src_ID), .src_used_ID(src_used_ID), .src_EX(src_EX),
        .waddr_EX(waddr_EX), .mem_read_EX(mem_read_EX),
        .waddr_MEM(waddr_MEM), .reg_write_MEM(reg_write_MEM),
        .waddr_WB(waddr_WB), .reg_write_WB(reg_write_WB),
        .redirect_MEM(redirect_MEM), .mem_busy(mem_busy),
        .fwd_sel(b_fwd), .pc_en(b_pc_en), .if_id_en(b_if_id_en),
        .id_ex_en(b_id_ex_en), .ex_mem_en(b_ex_mem_en), .mem_wb_en(b_mem_wb_en),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
        .ex_mem_flush(b_ex_mem_flush),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .wait_cnt(b_wait_cnt)
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .N_SRC(2), .LU_STALL(5), .CNT_W(2)) u_c (
        .clk(clk), .arst(arst), .enable(enable),
        .src_ID(src_ID), .src_used_ID(src_used_ID), .src_EX(src_EX),
        .waddr_EX(waddr_EX), .mem_read_EX(mem_read_EX),
        .waddr_MEM(waddr_MEM), .reg_write_MEM(reg_write_MEM),
        .waddr_WB(waddr_WB), .reg_write_WB(reg_write_WB),
        .redirect_MEM(redirect_MEM), .mem_busy(mem_busy),
        .fwd_sel(c_fwd), .pc_en(c_pc_en), .if_id_en(c_if_id_en),
        .id_ex_en(c_id_ex_en), .ex_mem_en(c_ex_mem_en), .mem_wb_en(c_mem_wb_en),
        .if_id_flush(c_if_id_flush), .id_ex_flush(c_id_ex_flush),
        .ex_mem_flush(c_ex_mem_flush),
        .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt), .wait_cnt(c_wait_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    // Drives the load-use related ID/EX inputs and lets them settle.
    task automatic applyStimulus(input logic mem_read, input logic [4:0] waddr,
                                 input logic [9:0] src, input logic [1:0] used);
        mem_read_EX = mem_read;
        waddr_EX    = waddr;
        src_ID      = src;
        src_used_ID = used;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst          = 1'b1;
        enable        = 1'b1;
        src_ID        = '0;
        src_used_ID   = '0;
        src_EX        = {5'd0, 5'd3};
        waddr_EX      = '0;
        mem_read_EX   = 1'b0;
        waddr_MEM     = 5'd3;
        reg_write_MEM = 1'b1;
        waddr_WB      = 5'd3;
        reg_write_WB  = 1'b1;
        redirect_MEM  = 1'b0;
        mem_busy      = 1'b0;

        // Reset: everything quiet even with a forwarding match present.
        #3;
        checkOutput("rst_fwd",       32'(a_fwd), 32'h0);
        checkOutput("rst_pc_en",     32'(a_pc_en), 32'h0);
        checkOutput("rst_mem_wb_en", 32'(a_mem_wb_en), 32'h0);
        checkOutput("rst_stall_cnt", 32'(a_stall_cnt), 32'h0);
        checkOutput("rst_flush_cnt", 32'(b_flush_cnt), 32'h0);

        @(posedge clk);
        #1 arst = 1'b0;
        #1;

        // Forwarding priority.
        checkOutput("fwd_mem_prio", 32'(a_fwd), 32'h1);
        checkOutput("run_pc_en",    32'(a_pc_en), 32'h1);
        reg_write_MEM = 1'b0;
        #1;
        checkOutput("fwd_wb", 32'(a_fwd), 32'h2);
        reg_write_MEM = 1'b1;
        waddr_MEM     = 5'd0;
        waddr_WB      = 5'd0;
        src_EX        = '0;
        #1;
        checkOutput("fwd_zero_reg", 32'(a_fwd), 32'h0);
        waddr_WB = 5'd7;
        src_EX   = {5'd7, 5'd0};
        #1;
        checkOutput("fwd_src1_wb", 32'(a_fwd), 32'h8);
        reg_write_MEM = 1'b0;
        reg_write_WB  = 1'b0;

        // Load-use qualification, checked combinationally within one cycle.
        tick();
        applyStimulus(1'b1, 5'd5, {5'd0, 5'd5}, 2'b00);
        checkOutput("lu_unused_src", 32'(a_pc_en), 32'h1);
        applyStimulus(1'b1, 5'd5, {5'd5, 5'd0}, 2'b10);
        checkOutput("lu_src1", 32'(a_pc_en), 32'h0);
        applyStimulus(1'b1, 5'd0, {5'd0, 5'd0}, 2'b11);
        checkOutput("lu_waddr0", 32'(a_pc_en), 32'h1);
        applyStimulus(1'b0, 5'd0, 10'd0, 2'b00);

        // Load-use stall: a stalls 1 cycle, b 3 cycles, c 5 cycles (saturating).
        tick();
        applyStimulus(1'b1, 5'd5, {5'd0, 5'd5}, 2'b01);
        checkOutput("lu1_pc_en",       32'(a_pc_en), 32'h0);
        checkOutput("lu1_if_id_en",    32'(a_if_id_en), 32'h0);
        checkOutput("lu1_id_ex_flush", 32'(a_id_ex_flush), 32'h1);
        checkOutput("lu1_id_ex_en",    32'(a_id_ex_en), 32'h1);
        checkOutput("lu3_c1_pc_en",    32'(b_pc_en), 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 10'd0, 2'b00);
        checkOutput("lu1_after_pc_en", 32'(a_pc_en), 32'h1);
        checkOutput("lu1_after_flush", 32'(a_id_ex_flush), 32'h0);
        checkOutput("lu1_stall_cnt",   32'(a_stall_cnt), 32'h1);
        checkOutput("lu3_c2_pc_en",    32'(b_pc_en), 32'h0);
        checkOutput("lu3_c2_flush",    32'(b_id_ex_flush), 32'h1);
        checkOutput("lu3_c2_cnt",      32'(b_stall_cnt), 32'h1);
        tick();
        checkOutput("lu3_c3_pc_en", 32'(b_pc_en), 32'h0);
        checkOutput("lu3_c3_cnt",   32'(b_stall_cnt), 32'h2);
        tick();
        checkOutput("lu3_done_pc_en", 32'(b_pc_en), 32'h1);
        checkOutput("lu3_stall_cnt",  32'(b_stall_cnt), 32'h3);
        checkOutput("lu1_cnt_held",   32'(a_stall_cnt), 32'h1);
        checkOutput("sat_mid_cnt",    32'(c_stall_cnt), 32'h3);
        checkOutput("sat_mid_pc_en",  32'(c_pc_en), 32'h0);
        tick();
        tick();
        checkOutput("sat_stall_cnt", 32'(c_stall_cnt), 32'h3);
        checkOutput("sat_done_pc_en", 32'(c_pc_en), 32'h1);

        // Redirect during the second stall cycle of b.
        applyStimulus(1'b1, 5'd5, {5'd0, 5'd5}, 2'b01);
        checkOutput("rd_c1_pc_en", 32'(b_pc_en), 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 10'd0, 2'b00);
        redirect_MEM = 1'b1;
        #1;
        checkOutput("rd_if_id_flush",  32'(b_if_id_flush), 32'h1);
        checkOutput("rd_id_ex_flush",  32'(b_id_ex_flush), 32'h1);
        checkOutput("rd_ex_mem_flush", 32'(b_ex_mem_flush), 32'h1);
        checkOutput("rd_pc_en",        32'(b_pc_en), 32'h1);
        checkOutput("rd_if_id_en",     32'(b_if_id_en), 32'h1);
        tick();
        redirect_MEM = 1'b0;
        #1;
        checkOutput("rd_flush_cnt", 32'(b_flush_cnt), 32'h1);
        checkOutput("rd_run_pc_en", 32'(b_pc_en), 32'h1);
        checkOutput("rd_run_flush", 32'(b_id_ex_flush), 32'h0);
        checkOutput("rd_stall_cnt", 32'(b_stall_cnt), 32'h4);

        // mem_busy overrides a concurrent redirect for 4 cycles.
        mem_busy     = 1'b1;
        redirect_MEM = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("busy_pc_en",     32'(a_pc_en), 32'h0);
            checkOutput("busy_mem_wb_en", 32'(a_mem_wb_en), 32'h0);
            checkOutput("busy_if_flush",  32'(a_if_id_flush), 32'h0);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checkOutput("busy_wait_cnt",  32'(a_wait_cnt), 32'h4);
        checkOutput("busy_rd_flush",  32'(a_ex_mem_flush), 32'h1);
        checkOutput("busy_rd_pc_en",  32'(a_pc_en), 32'h1);
        tick();
        redirect_MEM = 1'b0;
        #1;
        checkOutput("busy_flush_cnt", 32'(a_flush_cnt), 32'h2);

        // Global enable low freezes everything, even with a load-use hazard.
        enable = 1'b0;
        applyStimulus(1'b1, 5'd5, {5'd0, 5'd5}, 2'b01);
        checkOutput("en_low_id_ex_en", 32'(a_id_ex_en), 32'h0);
        checkOutput("en_low_flush",    32'(a_id_ex_flush), 32'h0);
        tick();
        checkOutput("en_low_cnt_held", 32'(a_stall_cnt), 32'h2);
        enable = 1'b1;
        #1;
        checkOutput("en_high_flush", 32'(a_id_ex_flush), 32'h1);

        // Asynchronous reset in the middle of c's stall.
        tick();
        applyStimulus(1'b0, 5'd0, 10'd0, 2'b00);
        checkOutput("arst_pre_flush", 32'(c_id_ex_flush), 32'h1);
        #2 arst = 1'b1;
        #1;
        checkOutput("arst_flush",     32'(c_id_ex_flush), 32'h0);
        checkOutput("arst_id_ex_en",  32'(c_id_ex_en), 32'h0);
        checkOutput("arst_stall_cnt", 32'(c_stall_cnt), 32'h0);
        checkOutput("arst_flush_cnt", 32'(a_flush_cnt), 32'h0);
        tick();
        arst = 1'b0;
        #1;
        checkOutput("arst_run_pc_en", 32'(c_pc_en), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
